// File: rtl/lut_sched_pkg.sv
// Shared types and defaults for the time-multiplexed LUT layer scheduler.
package lut_sched_pkg;

    localparam int N_NEURONS_DEF  = 32;
    localparam int FANIN_BITS_DEF = 8;
    localparam int OUT_BITS_DEF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } sched_state_t;

    // Width of the neuron index field; never below one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lut_layer_scheduler_if.sv
// Stream-in / stream-out / truth-table-config bundle of the LUT layer scheduler.
interface lut_layer_scheduler_if
    import lut_sched_pkg::*;
#(
    parameter int N_NEURONS  = N_NEURONS_DEF,
    parameter int FANIN_BITS = FANIN_BITS_DEF,
    parameter int OUT_BITS   = OUT_BITS_DEF
);
    localparam int IDX_W = idx_width(N_NEURONS);

    logic                            s_valid;
    logic                            s_ready;
    logic [N_NEURONS*FANIN_BITS-1:0] s_data;
    logic                            m_valid;
    logic                            m_ready;
    logic [N_NEURONS*OUT_BITS-1:0]   m_data;
    logic                            cfg_we;
    logic [IDX_W+FANIN_BITS-1:0]     cfg_addr;
    logic [OUT_BITS-1:0]             cfg_data;
    logic                            busy;

    modport slave (
        input  s_valid, s_data, m_ready, cfg_we, cfg_addr, cfg_data,
        output s_ready, m_valid, m_data, busy
    );

    modport master (
        output s_valid, s_data, m_ready, cfg_we, cfg_addr, cfg_data,
        input  s_ready, m_valid, m_data, busy
    );

endinterface

// File: rtl/lut_tt_ram.sv
// Truth-table store: simple dual-port, synchronous write, one-cycle registered read.
module lut_tt_ram
    import lut_sched_pkg::*;
#(
    parameter int N_NEURONS  = N_NEURONS_DEF,
    parameter int FANIN_BITS = FANIN_BITS_DEF,
    parameter int OUT_BITS   = OUT_BITS_DEF
)(
    input  logic                                         clk,
    input  logic                                         i_we,
    input  logic [idx_width(N_NEURONS)+FANIN_BITS-1:0]   i_waddr,
    input  logic [OUT_BITS-1:0]                          i_wdata,
    input  logic [idx_width(N_NEURONS)+FANIN_BITS-1:0]   i_raddr,
    output logic [OUT_BITS-1:0]                          o_rdata
);
    localparam int DEPTH = N_NEURONS * (2 ** FANIN_BITS);

    (* ram_style = "distributed" *) logic [OUT_BITS-1:0] r_mem [DEPTH];

    // Contents deliberately have no reset so programmed tables survive rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/lut_layer_scheduler.sv
// Evaluates one layer of LUT neurons by walking a shared truth-table RAM, one neuron per cycle.
module lut_layer_scheduler
    import lut_sched_pkg::*;
#(
    parameter int N_NEURONS  = N_NEURONS_DEF,
    parameter int FANIN_BITS = FANIN_BITS_DEF,
    parameter int OUT_BITS   = OUT_BITS_DEF
)(
    input  logic                  clk,
    input  logic                  rst,
    lut_layer_scheduler_if.slave  bus
);
    localparam int IDX_W  = idx_width(N_NEURONS);
    localparam int ADDR_W = IDX_W + FANIN_BITS;
    localparam int IN_W   = N_NEURONS * FANIN_BITS;
    localparam int OUT_W  = N_NEURONS * OUT_BITS;
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N_NEURONS - 1);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [IN_W-1:0]       r_vec;
    logic [IDX_W-1:0]      r_k;
    logic [IDX_W-1:0]      r_k_p1;
    logic                  r_vld_p1;
    logic [OUT_W-1:0]      r_m_data;
    logic                  w_accept;
    logic                  w_cfg_wr;
    logic [FANIN_BITS-1:0] w_slice;
    logic [ADDR_W-1:0]     w_raddr;
    logic [OUT_BITS-1:0]   w_rdata;

    assign bus.s_ready = (r_state == ST_IDLE) && !bus.cfg_we && !rst;
    assign w_accept    = bus.s_valid && bus.s_ready;
    assign w_cfg_wr    = bus.cfg_we && (r_state == ST_IDLE);

    assign w_slice = r_vec[int'(r_k) * FANIN_BITS +: FANIN_BITS];
    assign w_raddr = {r_k, w_slice};

    assign bus.m_valid = (r_state == ST_OUT);
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.m_data  = r_m_data;

    lut_tt_ram #(
        .N_NEURONS  (N_NEURONS),
        .FANIN_BITS (FANIN_BITS),
        .OUT_BITS   (OUT_BITS)
    ) u_tt_ram (
        .clk     (clk),
        .i_we    (w_cfg_wr),
        .i_waddr (bus.cfg_addr),
        .i_wdata (bus.cfg_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)          w_state_nxt = ST_RUN;
            ST_RUN:   if (r_k == K_LAST)     w_state_nxt = ST_DRAIN;
            ST_DRAIN:                        w_state_nxt = ST_OUT;
            ST_OUT:   if (bus.m_ready)       w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    // p0: address {k, slice k} issued in RUN; p1: RAM data back, captured next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_k      <= '0;
            r_k_p1   <= '0;
            r_vld_p1 <= 1'b0;
            r_m_data <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_vld_p1 <= (r_state == ST_RUN);
            r_k_p1   <= r_k;
            if (w_accept) begin
                r_k <= '0;
            end else if (r_state == ST_RUN) begin
                r_k <= r_k + IDX_W'(1);
            end
            if (r_vld_p1) begin
                r_m_data[int'(r_k_p1) * OUT_BITS +: OUT_BITS] <= w_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_vec <= bus.s_data;
        end
    end

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Directed and table-driven bench for lut_layer_scheduler with four neurons.
module tb_lut_layer_scheduler;

    localparam int NN = 4;
    localparam int FB = 8;
    localparam int OB = 2;

    typedef struct {
        logic [31:0] sd;
        logic [7:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] tt [NN][256];
    vec_t vt [6];

    lut_layer_scheduler_if #(.N_NEURONS(NN), .FANIN_BITS(FB), .OUT_BITS(OB)) bus ();

    lut_layer_scheduler #(.N_NEURONS(NN), .FANIN_BITS(FB), .OUT_BITS(OB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int n, input int e, input logic [1:0] v);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = {2'(n), 8'(e)};
        bus.cfg_data = v;
        tick();
        bus.cfg_we   = 1'b0;
        tt[n][e]     = v;
    endtask

    function automatic logic [7:0] model(input logic [31:0] sd);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < NN; i++) begin
            r[i*OB +: OB] = tt[i][sd[i*FB +: FB]];
        end
        return r;
    endfunction

    task automatic send(input logic [31:0] sd, input logic [7:0] exp, input string nm,
                        input int hold, input bit cfg_in_run);
        int         lat;
        logic [7:0] held;
        bus.s_valid = 1'b1;
        bus.s_data  = sd;
        #1;
        chk({nm, "_s_ready"}, 64'(bus.s_ready), 64'd1);
        tick();
        bus.s_valid = 1'b0;
        bus.s_data  = $urandom;
        if (cfg_in_run) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = {2'd0, 8'hB0};
            bus.cfg_data = 2'b11;
        end
        lat = 1;
        tick();
        while (!bus.m_valid && lat < 20) begin
            tick();
            lat++;
        end
        bus.cfg_we = 1'b0;
        chk({nm, "_latency"}, 64'(lat), 64'(NN + 1));
        chk({nm, "_m_data"}, 64'(bus.m_data), 64'(exp));
        held = bus.m_data;
        for (int i = 0; i < hold; i++) begin
            bus.s_valid = 1'b1;
            tick();
            chk({nm, "_hold"}, {bus.m_valid, bus.m_data, bus.s_ready, bus.busy},
                {1'b1, held, 1'b0, 1'b1});
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk({nm, "_idle_after"}, {bus.busy, bus.m_valid}, 2'b00);
    endtask

    initial begin
        bit stray;

        vt[0] = '{32'h0000_5CB0, 8'h06};
        vt[1] = '{32'hFF33_5CB0, 8'h76};
        vt[2] = '{32'h0000_0000, 8'h00};
        vt[3] = '{32'hFF00_0000, 8'h40};
        vt[4] = '{32'h0033_0000, 8'h30};
        vt[5] = '{32'h0000_B05C, 8'h00};

        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.m_ready  = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_state", {bus.busy, bus.m_valid, bus.m_data}, 10'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", 64'(bus.s_ready), 64'd1);

        for (int n = 0; n < NN; n++) begin
            for (int e = 0; e < 256; e++) begin
                cfg_write(n, e, 2'b00);
            end
        end
        cfg_write(0, 'hB0, 2'b10);
        cfg_write(1, 'h5C, 2'b01);
        cfg_write(2, 'h33, 2'b11);
        cfg_write(3, 'hFF, 2'b01);

        for (int i = 0; i < 6; i++) begin
            send(vt[i].sd, vt[i].exp, $sformatf("vec%0d", i), 0, 1'b0);
        end

        send(32'h0000_5CB0, 8'h06, "backpressure", 10, 1'b0);

        bus.cfg_we   = 1'b1;
        bus.cfg_addr = {2'd0, 8'h00};
        bus.cfg_data = 2'b11;
        bus.s_valid  = 1'b1;
        bus.s_data   = 32'h0;
        #1;
        chk("cfgpri_s_ready", 64'(bus.s_ready), 64'd0);
        tick();
        bus.cfg_we = 1'b0;
        tt[0][0]   = 2'b11;
        chk("cfgpri_not_accepted", 64'(bus.busy), 64'd0);
        send(32'h0, 8'h03, "cfgpri", 0, 1'b0);
        cfg_write(0, 'h00, 2'b00);

        bus.s_valid = 1'b1;
        bus.s_data  = 32'h0000_5CB0;
        tick();
        bus.s_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_state", {bus.busy, bus.m_valid, bus.m_data}, 10'd0);
        stray = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.m_valid || bus.busy) stray = 1'b1;
        end
        chk("abort_no_result", 64'(stray), 64'd0);
        send(32'h0000_5CB0, 8'h06, "after_rst", 0, 1'b0);

        send(32'h0000_5CB0, 8'h06, "cfg_in_run", 2, 1'b1);
        send(32'h0000_5CB0, 8'h06, "cfg_in_run_next", 0, 1'b0);

        for (int n = 0; n < NN; n++) begin
            for (int e = 0; e < 256; e++) begin
                cfg_write(n, e, 2'($urandom_range(0, 3)));
            end
        end
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] sd;
            sd = $urandom;
            send(sd, model(sd), $sformatf("rnd%0d", i), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
